// File: rtl/cam_capture_ctrl_if.sv
// Camera byte bus in, frame-buffer write port out. The master drives the
// camera side and receives writes; the slave is the capture controller.
interface cam_capture_ctrl_if #(
   parameter int ADDR_W = 17
);
   logic              cam_vsync;
   logic              cam_href;
   logic              cam_byte_valid;
   logic [7:0]        cam_data;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [11:0]       fb_data;

   modport master (
      output cam_vsync, cam_href, cam_byte_valid, cam_data,
      input  fb_we, fb_addr, fb_data
   );

   modport slave (
      input  cam_vsync, cam_href, cam_byte_valid, cam_data,
      output fb_we, fb_addr, fb_data
   );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Captures one RGB565 camera frame (two bytes per pixel) into a 12-bit RGB444
// frame buffer using raster addressing kept incrementally.
//
// state     | meaning
// S_IDLE    | capture not requested, camera bytes ignored
// S_ARM     | waiting for vsync falling edge (start of active frame)
// S_CAPTURE | pairing bytes into pixels, writing frame buffer
// S_DONE    | one-cycle frame_done, decide re-arm or idle
module cam_capture_ctrl #(
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240,
   parameter int ADDR_W   = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  capture_en,
   input  logic                  continuous,
   cam_capture_ctrl_if.slave     bus,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int PW = $clog2(H_PIXELS + 2);
   localparam int LW = $clog2(V_LINES + 2);
   localparam logic [PW-1:0]     PIX_FULL  = PW'(H_PIXELS);
   localparam logic [PW-1:0]     PIX_SAT   = PW'(H_PIXELS + 1);
   localparam logic [LW-1:0]     LINE_FULL = LW'(V_LINES);
   localparam logic [LW-1:0]     LINE_SAT  = LW'(V_LINES + 1);
   localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_PIXELS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t            state;
   logic              vsync_q;
   logic              href_q;
   logic              phase;
   logic [6:0]        hi_bits;
   logic [PW-1:0]     pix_cnt;
   logic [LW-1:0]     line_cnt;
   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] pix_addr;

   logic        vs_fall;
   logic        vs_rise;
   logic        href_fall;
   logic        pix_ok;
   logic [11:0] rgb444;

   assign vs_fall   = vsync_q & ~bus.cam_vsync;
   assign vs_rise   = ~vsync_q & bus.cam_vsync;
   assign href_fall = href_q & ~bus.cam_href;
   assign pix_ok    = (pix_cnt < PIX_FULL) && (line_cnt < LINE_FULL);
   // Only the RGB444 source bits of the high byte are kept: p[15:12] and p[10:8].
   assign rgb444    = {hi_bits, bus.cam_data[7], bus.cam_data[4:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         phase       <= 1'b0;
         hi_bits     <= '0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         line_base   <= '0;
         pix_addr    <= '0;
         bus.fb_we   <= 1'b0;
         bus.fb_addr <= '0;
         bus.fb_data <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         vsync_q    <= bus.cam_vsync;
         href_q     <= bus.cam_href;
         bus.fb_we  <= 1'b0;
         frame_done <= 1'b0;

         case (state)
            S_IDLE: begin
               phase <= 1'b0;
               if (capture_en) begin
                  state <= S_ARM;
                  busy  <= 1'b1;
               end
            end

            S_ARM: begin
               if (vs_fall) begin
                  state     <= S_CAPTURE;
                  pix_cnt   <= '0;
                  line_cnt  <= '0;
                  line_base <= '0;
                  pix_addr  <= '0;
                  phase     <= 1'b0;
                  frame_err <= 1'b0;
               end
            end

            S_CAPTURE: begin
               if (vs_rise) begin
                  state      <= S_DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  phase      <= 1'b0;
                  frame_err  <= frame_err | (line_cnt != LINE_FULL);
               end else if (!bus.cam_href) begin
                  phase <= 1'b0;
                  // Lines that delivered no complete pixel are not counted.
                  if (href_fall && (pix_cnt != '0)) begin
                     if (pix_cnt != PIX_FULL) frame_err <= 1'b1;
                     if (line_cnt != LINE_SAT) line_cnt <= line_cnt + 1'b1;
                     line_base <= line_base + H_STEP;
                     pix_addr  <= line_base + H_STEP;
                     pix_cnt   <= '0;
                  end
               end else if (bus.cam_byte_valid) begin
                  if (!phase) begin
                     hi_bits <= {bus.cam_data[7:4], bus.cam_data[2:0]};
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (pix_ok) begin
                        bus.fb_we   <= 1'b1;
                        bus.fb_addr <= pix_addr;
                        bus.fb_data <= rgb444;
                        pix_addr    <= pix_addr + 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                     if (pix_cnt != PIX_SAT) pix_cnt <= pix_cnt + 1'b1;
                  end
               end
            end

            S_DONE: begin
               if (continuous && capture_en) begin
                  state <= S_ARM;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with a write scoreboard fed by a
// byte-level reference model of pixel pairing, geometry checks and addressing.
module tb_cam_capture_ctrl;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic capture_en = 1'b0;
   logic continuous = 1'b0;
   logic busy, frame_done, frame_err;

   cam_capture_ctrl_if #(.ADDR_W(AW)) bus ();

   cam_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture_en (capture_en),
      .continuous (continuous),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [11:0]   data;
      int            cyc;
   } wr_t;

   wr_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   logic done_err = 1'b0;

   int         m_pix, m_line;
   bit         m_phase, m_err;
   logic [7:0] m_hi;

   logic [15:0] pix_set [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         if (bus.fb_we === 1'b1) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.fb_addr), 32'(e.addr));
               chk("wr_data", 32'(bus.fb_data), 32'(e.data));
               chk("wr_latency", cyc, e.cyc);
            end
         end
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_err = frame_err;
         end
      end
   end

   task automatic drive_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.cam_byte_valid = 1'b1;
      bus.cam_data       = b;
      if (!m_phase) begin
         m_hi    = b;
         m_phase = 1'b1;
      end else begin
         m_phase = 1'b0;
         if (m_pix < H && m_line < V)
            exp_q.push_back('{addr: AW'(m_line * H + m_pix),
                              data: {m_hi[7:4], m_hi[2:0], b[7], b[4:1]},
                              cyc:  cyc + 1});
         else
            m_err = 1'b1;
         if (m_pix < H + 1) m_pix++;
      end
      @(posedge clk); #1;
      bus.cam_byte_valid = 1'b0;
   endtask

   task automatic send_pixel(input logic [15:0] p);
      drive_byte(p[15:8]);
      drive_byte(p[7:0]);
   endtask

   task automatic line_begin();
      @(posedge clk); #1;
      bus.cam_href = 1'b1;
   endtask

   task automatic line_end();
      @(posedge clk); #1;
      bus.cam_href = 1'b0;
      m_phase = 1'b0;
      if (m_pix != 0) begin
         if (m_pix != H) m_err = 1'b1;
         if (m_line < V + 1) m_line++;
         m_pix = 0;
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic full_line();
      line_begin();
      for (int i = 0; i < 4; i++) send_pixel(pix_set[i]);
      line_end();
   endtask

   task automatic frame_begin();
      @(posedge clk); #1;
      bus.cam_vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.cam_vsync = 1'b0;
      m_pix = 0; m_line = 0; m_phase = 1'b0; m_err = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic frame_end(input string tag);
      int start;
      start = done_cnt;
      @(posedge clk); #1;
      bus.cam_vsync = 1'b1;
      if (m_line != V) m_err = 1'b1;
      for (int i = 0; i < 20 && done_cnt == start; i++) @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_seen"}, done_cnt - start, 1);
      chk({tag, "_frame_err"}, 32'(done_err), 32'(m_err));
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_done_single"}, done_cnt - start, 1);
      chk({tag, "_queue_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      bus.cam_vsync = 1'b1; bus.cam_href = 1'b0;
      bus.cam_byte_valid = 1'b0; bus.cam_data = 8'h00;

      #12;
      chk("rst_fb_we", 32'(bus.fb_we), 0);
      chk("rst_fb_addr", 32'(bus.fb_addr), 0);
      chk("rst_fb_data", 32'(bus.fb_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      @(negedge clk); rst_n = 1'b1;

      // Normal single frame
      capture_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("t1_busy_arm", 32'(busy), 1);
      frame_begin();
      full_line();
      capture_en = 1'b0;
      full_line();
      frame_end("t1");
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_addr_hold", 32'(bus.fb_addr), 7);
      chk("t1_data_hold", 32'(bus.fb_data), 32'h0FFF);

      // Long line: fifth pixel dropped
      capture_en = 1'b1;
      repeat (2) @(posedge clk);
      frame_begin();
      line_begin();
      for (int i = 0; i < 4; i++) send_pixel(pix_set[i]);
      send_pixel(16'h1234);
      line_end();
      capture_en = 1'b0;
      line_begin();
      send_pixel(16'hA5C3); send_pixel(16'h5A3C); send_pixel(16'h8421); send_pixel(16'h7BDE);
      line_end();
      frame_end("t3");

      // Odd trailing byte, single short line
      capture_en = 1'b1;
      repeat (2) @(posedge clk);
      frame_begin();
      line_begin();
      send_pixel(16'hF800); send_pixel(16'h07E0); send_pixel(16'h001F);
      drive_byte(8'hAB);
      line_end();
      capture_en = 1'b0;
      frame_end("t4");

      // Continuous capture, capture_en dropped during the third frame
      continuous = 1'b1;
      capture_en = 1'b1;
      repeat (2) @(posedge clk);
      for (int f = 0; f < 3; f++) begin
         frame_begin();
         full_line();
         if (f == 2) capture_en = 1'b0;
         full_line();
         frame_end("t5");
         chk("t5_busy_after", 32'(busy), (f < 2) ? 1 : 0);
      end
      continuous = 1'b0;

      // Asynchronous reset in the middle of a line
      capture_en = 1'b1;
      repeat (2) @(posedge clk);
      frame_begin();
      line_begin();
      send_pixel(16'hFFFF);
      drive_byte(8'h12);
      d0 = done_cnt;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_fb_we", 32'(bus.fb_we), 0);
      chk("t6_fb_addr", 32'(bus.fb_addr), 0);
      chk("t6_fb_data", 32'(bus.fb_data), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_frame_done", 32'(frame_done), 0);
      chk("t6_frame_err", 32'(frame_err), 0);
      bus.cam_href = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("t6_no_partial_done", done_cnt - d0, 0);
      frame_begin();
      full_line();
      capture_en = 1'b0;
      full_line();
      frame_end("t6_rearm");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
